octree_sram_xbar: RTL and testbench
===================================

// Module: octree_sram_xbar
// PURPOSE
//  Parametrised N-client x B-bank crossbar for the Octree local SRAM, replacing fixed searcher/updater mem_select muxing.
//  Clients (searcher, updater, future engines) issue req/gnt transactions; banks are word-interleaved 1-cycle-read SRAM macros.
//  Host (AXI) override grants the host exclusive access to all banks for test/preload.
//  Per-bank round-robin arbitration, tagged read-return routing and a saturating stall counter.
// PARAMETERS
//  NUM_CLIENTS  3   number of engine clients (>=1)
//  NUM_BANKS    2   SRAM banks, power of two (>=1)
//  ADDR_WIDTH   11  client/host word address width; bank = addr[log2(NB)-1:0], row = addr>>log2(NB)
//  DATA_WIDTH   64  word width
//  ROW_WIDTH    ADDR_WIDTH-$clog2(NUM_BANKS)  derived; 10 for a 1024x64 macro
// PORTS
//  clk          in   1                clock
//  rst_n        in   1                async active-low reset
//  client_en    in   NUM_CLIENTS      per-client enable; disabled clients never granted
//  cli_req      in   NUM_CLIENTS      request, held until granted
//  cli_we       in   NUM_CLIENTS      1 write, 0 read
//  cli_addr     in   [NC][ADDR_WIDTH] word address
//  cli_wdata    in   [NC][DATA_WIDTH] write data
//  cli_gnt      out  NUM_CLIENTS      combinational grant; transaction accepted this cycle
//  cli_rvalid   out  NUM_CLIENTS      read data valid, one cycle after read grant
//  cli_rdata    out  [NC][DATA_WIDTH] read data; 0 when rvalid=0
//  host_en      in   1                host override (csr_local_sram_en)
//  host_req     in   1                host access strobe
//  host_we      in   1                host write
//  host_addr    in   ADDR_WIDTH       host word address
//  host_wdata   in   DATA_WIDTH       host write data
//  host_rdata   out  DATA_WIDTH       host read data, valid cycle after host read; 0 otherwise
//  sram_req     out  NUM_BANKS        bank enable (active high)
//  sram_we      out  NUM_BANKS        bank write enable
//  sram_addr    out  [NB][ROW_WIDTH]  bank row address
//  sram_wdata   out  [NB][DATA_WIDTH] bank write data
//  sram_rdata   in   [NB][DATA_WIDTH] bank read data, 1-cycle latency
//  stat_clr     in   1                clears stall_cnt
//  stall_cnt    out  16               cycles with >=1 enabled ungranted request, saturating
// BEHAVIOUR
//  - Reset: cli_gnt/cli_rvalid=0, cli_rdata=0, host_rdata=0, sram_req/we=0, rr_ptr[b]=0, stall_cnt=0, tag regs cleared.
//  - host_en=1: all sram_* driven from host (only bank host_addr[bank] enabled on host_req); all cli_gnt=0; stall_cnt frozen.
//  - host_en=0: per bank b, candidates = client_en & cli_req & (bank(cli_addr)==b); winner = first candidate scanning
//    from rr_ptr[b] upward mod NC; cli_gnt[winner]=1, bank driven by winner; on grant rr_ptr[b] <= winner+1 mod NC.
//  - Clients hitting different banks granted in the same cycle; one grant per bank per cycle, max one per client.
//  - Read return: per bank, registered tag {valid, client id | host flag}; next cycle sram_rdata[b] routed to
//    cli_rdata[id] with cli_rvalid[id]=1 (or host_rdata). Writes produce no rvalid.
//  - host_en toggling mid-stream: reads granted in cycle t still return at t+1 to their original owner.
//  - stall_cnt: +1 per cycle (host_en=0) with any enabled, requesting, ungranted client; holds at 16'hFFFF;
//    stat_clr has priority over increment (counter=0 that cycle).
//  - cli_req from a disabled client: ignored, no gnt, does not count as stall.
//  - NUM_CLIENTS=1 / NUM_BANKS=1: pointer/bank fields sized max(1,clog2), logic degenerates cleanly.
//  - Async reset mid-transaction drops pending return tags; no rvalid after reset release.
// STRUCTURE
//  - octree_pkg: SRAM_DEPTH, DATA_WIDTH, ROW_WIDTH localparams; sram_sel_e (SRAM_NAN/SEARCHER/UPDATER) client ids;
//    rd_tag_t struct {logic vld; logic host; logic [CW-1:0] id}.
//  - Sub-module octree_rr_arbiter #(N): req vector + ptr -> one-hot gnt, winner idx; instantiated per bank.
//  - Top: bank decode, per-bank arbiter, output mux, tag pipeline, return demux, stall counter.
// TESTING
//  1 reset, host_en=1, host write 0xA5A5 @addr 5 then read @5 -> host_rdata=0xA5A5 next cycle, all cli_gnt=0.
//  2 host_en=0, clients 0,1,2 read bank0 continuously -> grants rotate 0,1,2,0; stall_cnt +1 every cycle.
//  3 client0 addr 4 (bank0), client1 addr 7 (bank1) same cycle -> both gnt=1; both rvalid next cycle with correct data.
//  4 client_en=3'b101, all request bank1 -> client1 never granted, grants alternate 0,2.
//  5 force stall 70000 cycles -> stall_cnt=16'hFFFF; assert stat_clr -> 0 next cycle.
//  6 client2 read granted, host_en rises next cycle -> cli_rvalid[2]=1 with data; host_rdata unaffected.

Source files
------------

// File: rtl/octree_sram_xbar_pkg.sv
// octree_pkg: shared sizes, client ids and read-return tag type for the Octree SRAM crossbar.
package octree_pkg;
    localparam int SRAM_DEPTH = 1024;
    localparam int DATA_WIDTH = 64;
    localparam int ROW_WIDTH  = $clog2(SRAM_DEPTH);
    localparam int CW         = 8;

    typedef enum logic [1:0] {SRAM_NAN, SEARCHER, UPDATER} sram_sel_e;

    // One tag per bank: marks a read in flight and who gets its data next cycle
    typedef struct packed {
        logic          vld;
        logic          host;
        logic [CW-1:0] id;
    } rd_tag_t;
endpackage

// File: rtl/octree_sram_xbar_rr_arbiter.sv
// octree_rr_arbiter: round-robin pick of the first request at or after ptr_i, wrapping mod N.
module octree_rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!vld_o && req_i[(int'(ptr_i) + i) % N]) begin
                vld_o = 1'b1;
                idx_o = PW'((int'(ptr_i) + i) % N);
            end
        end
        gnt_o = vld_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/octree_sram_xbar.sv
// octree_sram_xbar: N-client x B-bank word-interleaved SRAM crossbar with host override,
// per-bank round-robin arbitration, tagged read return and a saturating stall counter.
module octree_sram_xbar #(
    parameter int NUM_CLIENTS = 3,
    parameter int NUM_BANKS   = 2,
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 64,
    parameter int ROW_WIDTH   = ADDR_WIDTH - $clog2(NUM_BANKS)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_CLIENTS-1:0]                  client_en,
    input  logic [NUM_CLIENTS-1:0]                  cli_req,
    input  logic [NUM_CLIENTS-1:0]                  cli_we,
    input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0]  cli_addr,
    input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]  cli_wdata,
    output logic [NUM_CLIENTS-1:0]                  cli_gnt,
    output logic [NUM_CLIENTS-1:0]                  cli_rvalid,
    output logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]  cli_rdata,
    input  logic                                    host_en,
    input  logic                                    host_req,
    input  logic                                    host_we,
    input  logic [ADDR_WIDTH-1:0]                   host_addr,
    input  logic [DATA_WIDTH-1:0]                   host_wdata,
    output logic [DATA_WIDTH-1:0]                   host_rdata,
    output logic [NUM_BANKS-1:0]                    sram_req,
    output logic [NUM_BANKS-1:0]                    sram_we,
    output logic [NUM_BANKS-1:0][ROW_WIDTH-1:0]     sram_addr,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]    sram_wdata,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]    sram_rdata,
    input  logic                                    stat_clr,
    output logic [15:0]                             stall_cnt
);
    import octree_pkg::*;

    localparam int LB = $clog2(NUM_BANKS);
    localparam int BW = (NUM_BANKS > 1) ? LB : 1;
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    function automatic logic [BW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return BW'(a & ADDR_WIDTH'(NUM_BANKS - 1));
    endfunction

    function automatic logic [ROW_WIDTH-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        return ROW_WIDTH'(a >> LB);
    endfunction

    logic [NUM_BANKS-1:0][NUM_CLIENTS-1:0] cand, bank_gnt;
    logic [NUM_BANKS-1:0][IW-1:0]          win, rr_ptr_q, rr_ptr_d;
    logic [NUM_BANKS-1:0]                  bank_vld;
    rd_tag_t [NUM_BANKS-1:0]               tag_q, tag_d;
    logic [15:0]                           stall_q, stall_d;
    logic                                  stall_any;
    logic [BW-1:0]                         host_bank;

    assign host_bank = bank_of(host_addr);
    assign stall_cnt = stall_q;

    always_comb begin
        cand = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            for (int c = 0; c < NUM_CLIENTS; c++)
                cand[b][c] = !host_en && client_en[c] && cli_req[c] && (bank_of(cli_addr[c]) == BW'(b));
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        octree_rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
            .req_i (cand[b]),
            .ptr_i (rr_ptr_q[b]),
            .gnt_o (bank_gnt[b]),
            .idx_o (win[b]),
            .vld_o (bank_vld[b])
        );
    end

    always_comb begin
        cli_gnt    = '0;
        sram_req   = '0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        tag_d      = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            cli_gnt       = cli_gnt | bank_gnt[b];
            sram_req[b]   = host_en ? (host_req && host_bank == BW'(b)) : bank_vld[b];
            sram_we[b]    = sram_req[b] && (host_en ? host_we : cli_we[win[b]]);
            sram_addr[b]  = row_of(host_en ? host_addr : cli_addr[win[b]]);
            sram_wdata[b] = host_en ? host_wdata : cli_wdata[win[b]];
            tag_d[b]      = '{vld: sram_req[b] && !sram_we[b], host: host_en, id: CW'(win[b])};
            rr_ptr_d[b]   = (!host_en && bank_vld[b]) ? IW'((int'(win[b]) + 1) % NUM_CLIENTS) : rr_ptr_q[b];
        end
    end

    // Tags captured at grant time steer data regardless of what host_en does next cycle
    always_comb begin
        cli_rvalid = '0;
        cli_rdata  = '0;
        host_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (tag_q[b].vld && tag_q[b].host)
                host_rdata = host_rdata | sram_rdata[b];
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (tag_q[b].vld && !tag_q[b].host && tag_q[b].id == CW'(c)) begin
                    cli_rvalid[c] = 1'b1;
                    cli_rdata[c]  = cli_rdata[c] | sram_rdata[b];
                end
            end
        end
    end

    always_comb begin
        stall_any = !host_en && |(client_en & cli_req & ~cli_gnt);
        stall_d   = stat_clr ? '0 : (stall_any && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
            stall_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_octree_sram_xbar.sv
// tb_octree_sram_xbar: directed vector table plus hand sequences for host handover, saturation and reset.
module tb_octree_sram_xbar;
    localparam int NC = 3, NB = 2, AW = 11, DW = 64, RW = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic [NC-1:0] client_en, cli_req, cli_we, cli_gnt, cli_rvalid;
    logic [NC-1:0][AW-1:0] cli_addr;
    logic [NC-1:0][DW-1:0] cli_wdata, cli_rdata;
    logic host_en, host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic [NB-1:0] sram_req, sram_we;
    logic [NB-1:0][RW-1:0] sram_addr;
    logic [NB-1:0][DW-1:0] sram_wdata, sram_rdata;
    logic stat_clr;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    octree_sram_xbar dut (
        .clk(clk), .rst_n(rst_n), .client_en(client_en), .cli_req(cli_req), .cli_we(cli_we),
        .cli_addr(cli_addr), .cli_wdata(cli_wdata), .cli_gnt(cli_gnt), .cli_rvalid(cli_rvalid),
        .cli_rdata(cli_rdata), .host_en(host_en), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .stat_clr(stat_clr), .stall_cnt(stall_cnt)
    );

    logic [DW-1:0] mem [NB][1<<RW];

    always @(posedge clk)
        for (int b = 0; b < NB; b++)
            if (sram_req[b]) begin
                if (sram_we[b]) mem[b][sram_addr[b]] <= sram_wdata[b];
                else sram_rdata[b] <= mem[b][sram_addr[b]];
            end

    typedef struct {
        logic hen, hreq, hwe;
        logic [AW-1:0] ha;
        logic [DW-1:0] hw;
        logic [NC-1:0] en, req, we;
        logic [NC-1:0][AW-1:0] a;
        logic [DW-1:0] wd;
        logic clr;
        logic [NC-1:0] eg, ev;
        logic [NC-1:0][DW-1:0] er;
        logic [DW-1:0] ehr;
        logic [15:0] es;
    } vec_t;

    vec_t tv[$];
    int n_vec = 0, n_bad = 0;

    function automatic vec_t mk(logic hen, logic hreq, logic hwe, logic [AW-1:0] ha, logic [DW-1:0] hw,
                                logic [NC-1:0] en, logic [NC-1:0] req, logic [NC-1:0] we,
                                logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2, logic [DW-1:0] wd,
                                logic clr, logic [NC-1:0] eg, logic [NC-1:0] ev,
                                logic [DW-1:0] r0, logic [DW-1:0] r1, logic [DW-1:0] r2,
                                logic [DW-1:0] ehr, logic [15:0] es);
        vec_t v;
        v.hen = hen; v.hreq = hreq; v.hwe = hwe; v.ha = ha; v.hw = hw;
        v.en = en; v.req = req; v.we = we; v.a = {a2, a1, a0}; v.wd = wd; v.clr = clr;
        v.eg = eg; v.ev = ev; v.er = {r2, r1, r0}; v.ehr = ehr; v.es = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        host_en = 0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        client_en = '0; cli_req = '0; cli_we = '0; cli_addr = '0; cli_wdata = '0; stat_clr = 0;
    endtask

    task automatic step(input vec_t v, input int k);
        @(negedge clk);
        host_en = v.hen; host_req = v.hreq; host_we = v.hwe; host_addr = v.ha; host_wdata = v.hw;
        client_en = v.en; cli_req = v.req; cli_we = v.we; cli_addr = v.a;
        cli_wdata = {v.wd, v.wd, v.wd}; stat_clr = v.clr;
        #1 chk($sformatf("v%0d gnt", k), DW'(cli_gnt), DW'(v.eg));
        @(posedge clk);
        #1 chk($sformatf("v%0d rvalid", k), DW'(cli_rvalid), DW'(v.ev));
        for (int c = 0; c < NC; c++)
            chk($sformatf("v%0d rdata%0d", k, c), cli_rdata[c], v.er[c]);
        chk($sformatf("v%0d host_rdata", k), host_rdata, v.ehr);
        chk($sformatf("v%0d stall", k), DW'(stall_cnt), DW'(v.es));
    endtask

    initial begin
        tv.push_back(mk(1,1,1, 5,'hA5A5, 7,7,0, 0,2,6,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,1,0, 5,0,      7,7,0, 0,2,6,0, 0, 0,0, 0,0,0,'hA5A5, 0));
        tv.push_back(mk(1,0,0, 0,0,      0,0,0, 0,0,0,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,1,1, 4,'h4444, 0,0,0, 0,0,0,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,1,1, 7,'h7777, 0,0,0, 0,0,0,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,1,1, 0,'h1000, 0,0,0, 0,0,0,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,1,1, 2,'h2000, 0,0,0, 0,0,0,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(1,1,1, 6,'h6000, 0,0,0, 0,0,0,0, 0, 0,0, 0,0,0,0, 0));
        tv.push_back(mk(0,0,0, 0,0, 7,7,0, 0,2,6,0, 0, 1,1, 'h1000,0,0,0, 1));
        tv.push_back(mk(0,0,0, 0,0, 7,7,0, 0,2,6,0, 0, 2,2, 0,'h2000,0,0, 2));
        tv.push_back(mk(0,0,0, 0,0, 7,7,0, 0,2,6,0, 0, 4,4, 0,0,'h6000,0, 3));
        tv.push_back(mk(0,0,0, 0,0, 7,7,0, 0,2,6,0, 0, 1,1, 'h1000,0,0,0, 4));
        tv.push_back(mk(0,0,0, 0,0, 7,3,0, 4,7,0,0, 0, 3,3, 'h4444,'h7777,0,0, 4));
        tv.push_back(mk(0,0,0, 0,0, 7,4,4, 0,0,3,'h3333, 1, 4,0, 0,0,0,0, 0));
        tv.push_back(mk(0,0,0, 0,0, 7,4,0, 0,0,3,0, 0, 4,4, 0,0,'h3333,0, 0));
        tv.push_back(mk(0,0,0, 0,0, 5,7,0, 7,7,7,0, 0, 1,1, 'h7777,0,0,0, 1));
        tv.push_back(mk(0,0,0, 0,0, 5,7,0, 7,7,7,0, 0, 4,4, 0,0,'h7777,0, 2));
        tv.push_back(mk(0,0,0, 0,0, 5,7,0, 7,7,7,0, 0, 1,1, 'h7777,0,0,0, 3));
        tv.push_back(mk(0,0,0, 0,0, 5,7,0, 7,7,7,0, 0, 4,4, 0,0,'h7777,0, 4));
        tv.push_back(mk(0,0,0, 0,0, 0,7,0, 7,7,7,0, 0, 0,0, 0,0,0,0, 4));

        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("reset gnt", DW'(cli_gnt), 0);
        chk("reset rvalid", DW'(cli_rvalid), 0);
        chk("reset rdata", DW'(cli_rdata[0] | cli_rdata[1] | cli_rdata[2]), 0);
        chk("reset host_rdata", host_rdata, 0);
        chk("reset sram_req", DW'(sram_req), 0);
        chk("reset stall", DW'(stall_cnt), 0);

        for (int k = 0; k < tv.size(); k++) step(tv[k], k);

        // Client2 read granted, host takes over the next cycle: data still returns to client2
        @(negedge clk);
        idle();
        client_en = 3'b111; cli_req = 3'b100; cli_addr[2] = 11'd6;
        #1 chk("handover gnt", DW'(cli_gnt), 4);
        @(posedge clk);
        #1 host_en = 1; host_req = 1; host_addr = 11'd5; cli_req = '0;
        #1 chk("handover rvalid", DW'(cli_rvalid), 4);
        chk("handover rdata2", cli_rdata[2], 'h6000);
        chk("handover host_rdata", host_rdata, 0);
        chk("handover host gnt", DW'(cli_gnt), 0);
        @(posedge clk);
        #1 host_req = 0;
        chk("handover host read", host_rdata, 'hA5A5);
        chk("handover rvalid off", DW'(cli_rvalid), 0);

        // Long stall saturates the counter; stat_clr then wins over the increment
        @(negedge clk);
        idle();
        client_en = 3'b111; cli_req = 3'b111; cli_addr = {11'd6, 11'd2, 11'd0};
        repeat (70000) @(posedge clk);
        #1 chk("stall saturated", DW'(stall_cnt), 'hFFFF);
        stat_clr = 1;
        @(posedge clk);
        #1 chk("stall cleared", DW'(stall_cnt), 0);
        stat_clr = 0;
        @(posedge clk);
        #1 chk("stall restart", DW'(stall_cnt), 1);

        // Async reset while a read return is in flight drops it
        @(negedge clk);
        idle();
        client_en = 3'b001; cli_req = 3'b001; cli_addr[0] = 11'd0;
        @(posedge clk);
        #1 chk("pre-reset rvalid", DW'(cli_rvalid), 1);
        cli_req = '0;
        #1 rst_n = 0;
        #1 chk("async reset rvalid", DW'(cli_rvalid), 0);
        chk("async reset rdata0", cli_rdata[0], 0);
        chk("async reset stall", DW'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("post-reset rvalid", DW'(cli_rvalid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
